mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one transaction at a time.
// Tie-break: data port wins by default; define MEM_ARBITER_RR_EN to alternate on ties instead.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_owner_d;
  logic        r_wr;
  logic        r_mem_en;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_i_ack;
  logic        r_d_ack;
  logic [15:0] r_i_rdata;
  logic [15:0] r_d_rdata;
  logic        w_grant_d;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;
  // On a tie, serve whichever side did not complete the previous transaction.
  assign w_grant_d = d_req & (~i_req | ~r_last_d);
`else
  assign w_grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner_d   <= 1'b0;
      r_wr        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last_d    <= 1'b0;
`endif
    end else begin
      r_mem_en <= 1'b0;
      r_mem_wr <= 1'b0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req | d_req) begin
            r_owner_d   <= w_grant_d;
            r_wr        <= w_grant_d & d_wr;
            r_mem_addr  <= w_grant_d ? d_addr : i_addr;
            r_mem_wdata <= w_grant_d ? d_wdata : 16'h0000;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= w_grant_d & d_wr;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 4'(LATENCY);
          r_state <= WAIT;
        end
        WAIT: begin
          // WAIT always spans LATENCY cycles, so even LATENCY=1 captures one cycle after ISSUE.
          if (r_cnt == 4'd1) begin
            r_cnt   <= '0;
            r_state <= DONE;
            r_d_ack <= r_owner_d;
            r_i_ack <= ~r_owner_d;
            if (!r_wr) begin
              if (r_owner_d) r_d_rdata <= mem_rdata;
              else           r_i_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
`ifdef MEM_ARBITER_RR_EN
          r_last_d <= r_owner_d;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of grant order, timing and read data versus a delayed memory.
// Runs a LATENCY=4 instance for most traffic and a LATENCY=1 instance for the short-latency case.
module tb_mem_arbiter;

  localparam int L = 4;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_en, mem_wr, i_ack, d_ack, busy;
  logic [15:0] mem_addr, mem_wdata, i_rdata, d_rdata;

  logic        i1_req, d1_req, d1_wr;
  logic [15:0] i1_addr, d1_addr, d1_wdata, mem_rdata1;
  logic        mem_en1, mem_wr1, i_ack1, d_ack1, busy1;
  logic [15:0] mem_addr1, mem_wdata1, i_rdata1, d_rdata1;

  logic [15:0] mem  [65536];
  logic [15:0] refm [65536];
  logic [15:0] m_i_rdata, m_d_rdata;
  bit          m_last_d;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  bit          pend4, pend1;
  int          due4, due1;
  logic [15:0] paddr4, paddr1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata), .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i1_req), .i_addr(i1_addr),
    .d_req(d1_req), .d_wr(d1_wr), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .mem_rdata(mem_rdata1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .i_ack(i_ack1), .i_rdata(i_rdata1), .d_ack(d_ack1), .d_rdata(d_rdata1), .busy(busy1)
  );

  // Memories: read data is valid only in the cycle LATENCY after the strobe, noise otherwise.
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdata = (pend4 && cyc == due4) ? mem[paddr4] : 16'($urandom);
    end
  end
  initial forever begin
    @(negedge clk);
    if (mem_en === 1'b1) begin
      if (mem_wr === 1'b1) mem[mem_addr] = mem_wdata;
      else begin pend4 = 1'b1; due4 = cyc + L; paddr4 = mem_addr; end
    end
  end
  initial begin
    mem_rdata1 = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdata1 = (pend1 && cyc == due1) ? mem[paddr1] : 16'($urandom);
    end
  end
  initial forever begin
    @(negedge clk);
    if (mem_en1 === 1'b1 && mem_wr1 !== 1'b1) begin
      pend1 = 1'b1; due1 = cyc + 1; paddr1 = mem_addr1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Runs one request pattern; nhold>0 keeps both requests high for nhold completions.
  task automatic serve(input bit ri, input bit rd, input bit wr,
                       input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                       input bit early, input int nhold);
    bit own [8];
    int n, last_ack, nmax, b;
    bit pi, pd, lst, ei, ed, eb, ee;
    n = 0; pi = ri; pd = rd; lst = m_last_d;
    nmax = (nhold > 0) ? nhold : 2;
    while ((pi || pd) && n < nmax) begin
      own[n] = pd && (!pi || !RR || !lst);
      lst = own[n];
      if (nhold == 0) begin
        if (own[n]) pd = 1'b0;
        else        pi = 1'b0;
      end
      n++;
    end
    last_ack = (n - 1) * (L + 3) + 2 + L;
    @(posedge clk); #1;
    i_req = ri; i_addr = ia; d_req = rd; d_wr = wr; d_addr = da; d_wdata = wd;
    for (int k = 0; k <= last_ack; k++) begin
      @(negedge clk);
      ee = 0; eb = 0; ei = 0; ed = 0;
      for (int s = 0; s < n; s++) begin
        b = s * (L + 3);
        if (k == b + 1) begin
          ee = 1;
          chk("mem_addr", mem_addr, own[s] ? da : ia);
          chk("mem_wr", mem_wr, own[s] & wr);
          if (own[s] && wr) chk("mem_wdata", mem_wdata, wd);
        end
        if (k >= b + 1 && k <= b + 2 + L) eb = 1;
        if (k == b + 2 + L) begin
          if (own[s]) begin
            ed = 1;
            if (wr) refm[da] = wd;
            else    m_d_rdata = refm[da];
          end else begin
            ei = 1;
            m_i_rdata = refm[ia];
          end
          m_last_d = own[s];
        end
      end
      chk("mem_en", mem_en, ee);
      chk("busy", busy, eb);
      chk("i_ack", i_ack, ei);
      chk("d_ack", d_ack, ed);
      chk("i_rdata", i_rdata, m_i_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      @(posedge clk); #1;
      if (nhold > 0) begin
        if (k >= last_ack) begin i_req = 0; d_req = 0; end
      end else begin
        if (early && k == 0) begin i_req = 0; d_req = 0; end
        if (ei) i_req = 0;
        if (ed) d_req = 0;
      end
    end
  endtask

  int          sel;
  bit          r_i, r_d, r_w, r_e;
  logic [15:0] r_ia, r_da, r_wd;

  initial begin
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i1_req = 0; d1_req = 0; d1_wr = 0; i1_addr = 0; d1_addr = 0; d1_wdata = 0;
    pend4 = 0; pend1 = 0; due4 = 0; due1 = 0; paddr4 = 0; paddr1 = 0;
    for (int a = 0; a < 65536; a++) begin
      mem[a]  = 16'(a * 40503) ^ 16'h5A5A;
      refm[a] = 16'(a * 40503) ^ 16'h5A5A;
    end
    mem[16'h0010] = 16'hABCD; refm[16'h0010] = 16'hABCD;
    m_i_rdata = '0; m_d_rdata = '0; m_last_d = 1'b0;

    #2;
    chk("reset_ctrl", {busy, mem_en, mem_wr, i_ack, d_ack}, 0);
    chk("reset_mem_bus", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", {i_rdata, d_rdata}, 0);
    chk("reset_l1_busy", busy1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Single fetch, then a tie, then a data write, then a request dropped after grant.
    serve(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0);
    chk("fetch_data", i_rdata, 16'hABCD);
    serve(1, 1, 0, 16'h0020, 16'h0200, 16'h0000, 0, 0);
    serve(0, 1, 1, 16'h0000, 16'h0040, 16'h1234, 0, 0);
    serve(0, 1, 0, 16'h0000, 16'h0041, 16'h0000, 1, 0);
    serve(1, 0, 0, 16'h0042, 16'h0000, 16'h0000, 1, 0);

    // Abort a fetch in its WAIT phase with an asynchronous reset.
    @(posedge clk); #1;
    i_req = 1; i_addr = 16'h0300;
    repeat (3) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_en, mem_wr}, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    i_req = 0;
    m_i_rdata = '0; m_d_rdata = '0; m_last_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold", {i_ack, d_ack, busy, mem_en}, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {i_ack, d_ack, busy, mem_en}, 0);
    end
    serve(1, 0, 0, 16'h0301, 16'h0000, 16'h0000, 0, 0);

    // Both requests held across four completions.
    serve(1, 1, 0, 16'h0030, 16'h0031, 16'h0000, 0, 4);

    // LATENCY=1 data read on the second instance.
    @(posedge clk); #1;
    d1_req = 1; d1_addr = 16'h0555;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("l1_mem_en", mem_en1, k == 1);
      chk("l1_d_ack", d_ack1, k == 3);
      chk("l1_i_ack", i_ack1, 0);
      chk("l1_busy", busy1, k >= 1);
      if (k == 3) chk("l1_d_rdata", d_rdata1, refm[16'h0555]);
      @(posedge clk); #1;
      if (k == 3) d1_req = 0;
    end

    for (int t = 0; t < 24; t++) begin
      sel  = $urandom_range(1, 3);
      r_i  = sel[0];
      r_d  = sel[1];
      r_w  = 1'($urandom_range(0, 1));
      r_e  = (sel != 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      r_ia = 16'h0100 + 16'($urandom_range(0, 31));
      r_da = 16'h0100 + 16'($urandom_range(0, 31));
      r_wd = 16'($urandom);
      serve(r_i, r_d, r_w, r_ia, r_da, r_wd, r_e, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
